// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: controller mode encoding,
// active-low 7-segment glyphs (gfedcba) and display geometry.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN1  = 2'd1,
    RUN10 = 2'd2,
    PAUSE = 2'd3
  } mode_e;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_OFF = 7'b1111111;

  // BCD digit to active-low segment pattern; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_glyph(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sw_bcd_cell.sv
// One BCD counter digit of the stopwatch carry chain, counting 0..MOD-1.
module sw_bcd_cell #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  // Carry out is combinational so the whole chain advances on one edge.
  assign carry = inc && (q == LAST);

  // Digit register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (clr)    q <= '0;
    else if (carry)  q <= '0;
    else if (inc)    q <= q + 4'd1;
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch datapath: prescaler, SS.hh BCD time and multiplexed
// active-low 4-digit 7-segment display.
// Optional macro SW_LAP_EN: lap pulse freezes the displayed value.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  mode_e       mode,
  input  logic        lap,
  output logic [15:0] digits,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] TERM1  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] TERM10 = PW'(TICK_DIV / 10 - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  mode_e          prev_mode;
  logic [PW-1:0]  presc, presc_nxt, term;
  logic           tick, clr_time, running, prev_running;
  logic [3:0]     q0, q1, q2, q3;
  logic           c0, c1, c2, c3;
  logic [SW-1:0]  scan_cnt;
  logic [DW-1:0]  sel;
  logic [15:0]    disp;
  logic [3:0]     disp_digit;

  assign running      = (mode == RUN1) || (mode == RUN10);
  assign prev_running = (prev_mode == RUN1) || (prev_mode == RUN10);
  assign term         = (mode == RUN10) ? TERM10 : TERM1;

  // Prescaler next state and tick generation.
  // Entering a run mode from CLEAR (prescaler already zero) or PAUSE counts
  // on the first edge; entering PAUSE holds. Only a direct RUN1<->RUN10
  // switch therefore needs the explicit clear.
  always_comb begin
    presc_nxt = presc;
    tick      = 1'b0;
    clr_time  = 1'b0;
    if (mode == CLEAR) begin
      presc_nxt = '0;
      clr_time  = 1'b1;
    end else if (running) begin
      if (prev_running && (prev_mode != mode)) begin
        presc_nxt = '0;
      end else if (presc == term) begin
        presc_nxt = '0;
        tick      = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  // Prescaler, previous-mode and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      prev_mode <= CLEAR;
      wrap      <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      prev_mode <= mode;
      wrap      <= c3;
    end
  end

  sw_bcd_cell #(.MOD(10)) u_hund_units (
    .clk(clk), .rst(rst), .clr(clr_time), .inc(tick), .q(q0), .carry(c0)
  );
  sw_bcd_cell #(.MOD(10)) u_hund_tens (
    .clk(clk), .rst(rst), .clr(clr_time), .inc(c0), .q(q1), .carry(c1)
  );
  sw_bcd_cell #(.MOD(10)) u_sec_units (
    .clk(clk), .rst(rst), .clr(clr_time), .inc(c1), .q(q2), .carry(c2)
  );
  sw_bcd_cell #(.MOD(6)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clr_time), .inc(c2), .q(q3), .carry(c3)
  );

  assign digits = {q3, q2, q1, q0};

`ifdef SW_LAP_EN
  logic        frozen;
  logic [15:0] freeze;

  // Lap latch: first lap while running freezes the display, second releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
      freeze <= '0;
    end else if (mode == CLEAR) begin
      frozen <= 1'b0;
    end else if (lap && running) begin
      if (frozen) begin
        frozen <= 1'b0;
      end else begin
        frozen <= 1'b1;
        freeze <= digits;
      end
    end
  end

  assign disp = frozen ? freeze : digits;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = digits;
`endif

  assign disp_digit = disp[{sel, 2'b00} +: 4];

  // Free-running scan counter and digit select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sel      <= sel + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Display outputs registered together so segments always match the anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n  <= 4'b1110;
      seg_n <= GLYPH_0;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= ~(4'b0001 << sel);
      seg_n <= seg_glyph(disp_digit);
      dp_n  <= (sel != DW'(2));
    end
  end

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with TICK_DIV=20, SCAN_DIV=4.
// Lap checks are compiled in when SW_LAP_EN is defined.
module tb_stopwatch_timebase;
  import stopwatch_pkg::*;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12;

  logic        clk = 1'b0;
  logic        rst;
  mode_e       mode;
  logic        lap;
  logic [15:0] digits;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        wrap;

  int unsigned total = 0;
  int unsigned bad   = 0;

  stopwatch_timebase #(.TICK_DIV(20), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .lap(lap), .digits(digits),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, digits, 16'h0000);
    chk({tag, "_an"}, {12'd0, an_n}, 16'h000E);
    chk({tag, "_seg"}, {9'd0, seg_n}, 16'h0040);
    chk({tag, "_dp"}, {15'd0, dp_n}, 16'h0001);
    chk({tag, "_wrap"}, {15'd0, wrap}, 16'h0000);
  endtask

  // Wait for a fresh digit-0 slot, then check all four slots, four cycles each.
  task automatic check_scan(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3);
    logic [3:0]  prev;
    logic [6:0]  g [4];
    logic [3:0]  an_exp;
    int unsigned n;
    logic        found;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    prev = an_n;
    n = 0;
    @(negedge clk);
    while (!(an_n == 4'b1110 && prev != 4'b1110) && n < 40) begin
      prev = an_n;
      @(negedge clk);
      n++;
    end
    found = (n < 40);
    chk({tag, "_sync"}, {15'd0, found}, 16'h0001);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        an_exp = ~(4'b0001 << d);
        for (int c = 0; c < 4; c++) begin
          if (d != 0 || c != 0) @(negedge clk);
          chk($sformatf("%s_an_d%0d_c%0d", tag, d, c), {12'd0, an_n}, {12'd0, an_exp});
          chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {9'd0, seg_n}, {9'd0, g[d]});
          chk($sformatf("%s_dp_d%0d_c%0d", tag, d, c), {15'd0, dp_n},
              (d == 2) ? 16'h0000 : 16'h0001);
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = CLEAR;
    lap  = 1'b0;
    #1;
    chk_reset_outputs("reset");
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // RUN1: 100 ticks of 20 cycles
    mode = RUN1;
    cyc(1999);
    chk("run1_1999", digits, 16'h0099);
    cyc(1);
    chk("run1_2000", digits, 16'h0100);

    // RUN10: 100 ticks of 2 cycles
    mode = CLEAR;
    cyc(2);
    chk("clear", digits, 16'h0000);
    mode = RUN10;
    cyc(200);
    chk("run10_200", digits, 16'h0100);

    // RUN1 -> RUN10 clears prescaler; first tick two edges after the switch
    mode = CLEAR;
    cyc(2);
    mode = RUN1;
    cyc(10);
    mode = RUN10;
    cyc(1);
    chk("switch_e1", digits, 16'h0000);
    cyc(1);
    chk("switch_e2", digits, 16'h0000);
    cyc(1);
    chk("switch_e3", digits, 16'h0001);

    // Wrap 59.99 -> 00.00
    mode = CLEAR;
    cyc(2);
    mode = RUN10;
    cyc(11998);
    chk("wrap_pre_digits", digits, 16'h5999);
    chk("wrap_pre_flag", {15'd0, wrap}, 16'h0000);
    cyc(1);
    chk("wrap_mid_digits", digits, 16'h5999);
    chk("wrap_mid_flag", {15'd0, wrap}, 16'h0000);
    cyc(1);
    chk("wrap_digits", digits, 16'h0000);
    chk("wrap_flag", {15'd0, wrap}, 16'h0001);
    cyc(1);
    chk("wrap_after_flag", {15'd0, wrap}, 16'h0000);

    // Pause holds and resumes exactly
    mode = CLEAR;
    cyc(2);
    mode = RUN1;
    cyc(30);
    chk("pause_run30", digits, 16'h0001);
    mode = PAUSE;
    cyc(500);
    chk("pause_hold", digits, 16'h0001);
    mode = RUN1;
    cyc(10);
    chk("pause_resume", digits, 16'h0002);

    // Asynchronous reset mid-run, then count from 00.00
    cyc(5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc(19);
    chk("post_rst_19", digits, 16'h0000);
    cyc(1);
    chk("post_rst_20", digits, 16'h0001);

    // Display scan of 12.34
    mode = CLEAR;
    cyc(2);
    mode = RUN10;
    cyc(2468);
    chk("scan_value", digits, 16'h1234);
    mode = PAUSE;
    cyc(1);
    check_scan("scan1234", G4, G3, G2, G1);

`ifdef SW_LAP_EN
    mode = CLEAR;
    cyc(3);
    mode = RUN1;
    cyc(1000);
    chk("lap_pre", digits, 16'h0050);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    cyc(999);
    chk("lap_live", digits, 16'h0100);
    mode = PAUSE;
    cyc(1);
    check_scan("lap_frozen", G0, G5, G0, G0);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check_scan("lap_paused_ignored", G0, G5, G0, G0);
    mode = RUN1;
    lap  = 1'b1;
    cyc(1);
    lap  = 1'b0;
    mode = PAUSE;
    cyc(1);
    chk("lap_release_digits", digits, 16'h0100);
    check_scan("lap_released", G0, G0, G1, G0);
    mode = RUN1;
    lap  = 1'b1;
    cyc(1);
    lap  = 1'b0;
    mode = CLEAR;
    cyc(3);
    chk("lap_clear_digits", digits, 16'h0000);
    check_scan("lap_clear", G0, G0, G0, G0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
